// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman pass sequencer: state encoding,
// error-bit positions, pass-count derivation and the array scoring constants.
package sw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_RECIRC = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int unsigned ERR_UNDERRUN = 0;
  localparam int unsigned ERR_OVERRUN  = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;

  localparam int unsigned DEF_INPUT_LENGTH = 256;
  localparam int unsigned DEF_PE_LENGTH    = 128;

  // Scoring constants used by the PE cells.
  localparam int SC_MATCH = 2;
  localparam int SC_MISS  = -1;
  localparam int SC_GAP   = -1;

  function automatic int unsigned num_pass(int unsigned il, int unsigned pe);
    return il / pe;
  endfunction

  localparam int unsigned NUM_PASS = num_pass(DEF_INPUT_LENGTH, DEF_PE_LENGTH);

endpackage

// File: rtl/sw_edge_wd.sv
// Edge detector on the PE-array valid_out plus a saturating watchdog that is
// cleared on state entry and on every valid_out edge.
module sw_edge_wd #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned WD_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pv,
  input  logic i_restart,
  output logic o_rise,
  output logic o_fall,
  output logic o_expire
);

  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  logic            r_pv_d;
  logic [WD_W-1:0] r_wd;
  logic            w_rise;
  logic            w_fall;

  assign w_rise   = i_pv & ~r_pv_d;
  assign w_fall   = ~i_pv & r_pv_d;
  assign o_rise   = w_rise;
  assign o_fall   = w_fall;
  assign o_expire = (r_wd == WD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv_d <= 1'b0;
      r_wd   <= '0;
    end else begin
      r_pv_d <= i_pv;
      if (i_restart || w_rise || w_fall)
        r_wd <= '0;
      else if (r_wd != WD_MAX)
        r_wd <= r_wd + WD_W'(1);
    end
  end

endmodule

// File: rtl/sw_pass_ctrl.sv
// Pass sequencer for the Smith-Waterman systolic array: loads the query
// stream, recirculates it for the remaining passes and flags stream errors.
module sw_pass_ctrl
  import sw_pkg::*;
#(
  parameter int unsigned INPUT_LENGTH = 256,
  parameter int unsigned PE_LENGTH    = 128,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic       pe_valid_out,
  output logic       in_accept,
  output logic       src_sel,
  output logic       pe_clear,
  output logic [1:0] pass_idx,
  output logic       busy,
  output logic       max_hold,
  output logic       finish,
  output logic [2:0] err
);

  localparam int unsigned     N_PASS    = num_pass(INPUT_LENGTH, PE_LENGTH);
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(INPUT_LENGTH);
  localparam logic [1:0]       PASS_LAST = 2'(N_PASS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [1:0]       r_pass_idx;
  logic             r_in_accept;
  logic             r_src_sel;
  logic             r_pe_clear;
  logic             r_busy;
  logic             r_max_hold;
  logic             r_finish;
  logic [2:0]       r_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_beat_nxt;
  logic [1:0]       w_pass_nxt;
  logic             w_acc_nxt;
  logic [2:0]       w_err_nxt;
  logic             w_last_pass;
  logic             w_rise;
  logic             w_fall;
  logic             w_expire;
  logic             w_restart;

  assign w_restart = (w_state_nxt != r_state);

  sw_edge_wd #(.TIMEOUT(TIMEOUT)) u_edge_wd (
    .clk       (clk),
    .rst_n     (reset),
    .i_pv      (pe_valid_out),
    .i_restart (w_restart),
    .o_rise    (w_rise),
    .o_fall    (w_fall),
    .o_expire  (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_pass_nxt  = r_pass_idx;
    w_acc_nxt   = 1'b0;
    w_err_nxt   = r_err;
    w_last_pass = (r_pass_idx == PASS_LAST);
    case (r_state)
      ST_IDLE: begin
        if (valid) begin
          w_acc_nxt   = 1'b1;
          w_beat_nxt  = CNT_W'(1);
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (valid) begin
          if (r_beat_cnt < LEN) begin
            w_acc_nxt  = 1'b1;
            w_beat_nxt = r_beat_cnt + CNT_W'(1);
          end else begin
            w_err_nxt[ERR_OVERRUN] = 1'b1;
          end
        end else begin
          if (r_beat_cnt < LEN)
            w_err_nxt[ERR_UNDERRUN] = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_fall)
          w_state_nxt = w_last_pass ? ST_DONE : ST_CLEAR;
        else if (w_expire && !w_rise) begin
          w_err_nxt[ERR_TIMEOUT] = 1'b1;
          w_state_nxt            = ST_DONE;
        end
      end
      ST_CLEAR: begin
        // The first recirculated beat may already be on valid_out during the clear cycle.
        w_beat_nxt  = CNT_W'(pe_valid_out);
        w_pass_nxt  = w_last_pass ? r_pass_idx : r_pass_idx + 2'd1;
        w_state_nxt = ST_RECIRC;
      end
      ST_RECIRC: begin
        if (pe_valid_out && (r_beat_cnt != '1))
          w_beat_nxt = r_beat_cnt + CNT_W'(1);
        if (w_fall) begin
          if (r_beat_cnt < LEN) w_err_nxt[ERR_UNDERRUN] = 1'b1;
          if (r_beat_cnt > LEN) w_err_nxt[ERR_OVERRUN]  = 1'b1;
          w_state_nxt = w_last_pass ? ST_DONE : ST_CLEAR;
        end else if (w_expire && !w_rise) begin
          w_err_nxt[ERR_TIMEOUT] = 1'b1;
          w_state_nxt            = ST_DONE;
        end
      end
      ST_DONE: begin
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_pass_idx  <= '0;
      r_in_accept <= 1'b0;
      r_src_sel   <= 1'b0;
      r_pe_clear  <= 1'b0;
      r_busy      <= 1'b0;
      r_max_hold  <= 1'b0;
      r_finish    <= 1'b0;
      r_err       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_pass_idx  <= w_pass_nxt;
      r_in_accept <= w_acc_nxt;
      r_err       <= w_err_nxt;
      r_src_sel   <= (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_CLEAR) ||
                     (w_state_nxt == ST_RECIRC);
      r_pe_clear  <= (w_state_nxt == ST_CLEAR);
      r_busy      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
      r_max_hold  <= (w_state_nxt == ST_DONE);
      r_finish    <= (r_state == ST_DONE);
    end
  end

  assign in_accept = r_in_accept;
  assign src_sel   = r_src_sel;
  assign pe_clear  = r_pe_clear;
  assign pass_idx  = r_pass_idx;
  assign busy      = r_busy;
  assign max_hold  = r_max_hold;
  assign finish    = r_finish;
  assign err       = r_err;

endmodule

// File: tb/tb_sw_pass_ctrl.sv
// Scoreboard bench for sw_pass_ctrl: runs are summarised by a reference model
// and checked by a monitor when finish rises.
module tb_sw_pass_ctrl;

  localparam int IL = 256;
  localparam int PL = 128;
  localparam int NP = IL / PL;
  localparam int TO = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic       pe_valid_out = 1'b0;
  logic       in_accept, src_sel, pe_clear, busy, max_hold, finish;
  logic [1:0] pass_idx;
  logic [2:0] err;

  sw_pass_ctrl #(
    .INPUT_LENGTH (IL),
    .PE_LENGTH    (PL),
    .CNT_W        (10),
    .TIMEOUT      (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .pe_valid_out (pe_valid_out),
    .in_accept    (in_accept),
    .src_sel      (src_sel),
    .pe_clear     (pe_clear),
    .pass_idx     (pass_idx),
    .busy         (busy),
    .max_hold     (max_hold),
    .finish       (finish),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         acc;
    int         clr;
    logic [2:0] err;
    logic [1:0] pidx;
    int         src_dly;
    bit         stall;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Run-level reference: what a whole run must look like from its stimulus alone.
  function automatic exp_t model(input int b, input int l2, input bit stall);
    exp_t e;
    e.acc     = (b < IL) ? b : IL;
    e.clr     = stall ? 0 : NP - 1;
    e.pidx    = stall ? 2'd0 : 2'(NP - 1);
    e.src_dly = b;
    e.stall   = stall;
    e.err[0]  = (b < IL) || (!stall && l2 < IL);
    e.err[1]  = (b > IL) || (!stall && l2 > IL);
    e.err[2]  = stall;
    return e;
  endfunction

  int   cyc = 0;
  int   m_acc, m_clr, first_acc, first_src, mh_cyc;
  bit   prev_fin, prev_mh;
  exp_t m_e;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      m_acc = 0; m_clr = 0; first_acc = -1; first_src = -1; mh_cyc = -1;
      prev_fin = 1'b0; prev_mh = 1'b0;
    end else begin
      if (in_accept) begin
        m_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (pe_clear) m_clr++;
      if (src_sel && first_src < 0) first_src = cyc;
      if (max_hold && !prev_mh) mh_cyc = cyc;
      if (finish && !prev_fin) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_finish: got finish=1 at cycle %0d, expected no run pending", cyc);
        end else begin
          m_e = exp_q.pop_front();
          check("accept_count", m_acc, m_e.acc);
          check("clear_pulses", m_clr, m_e.clr);
          check("err_flags", err, m_e.err);
          check("pass_idx_final", pass_idx, m_e.pidx);
          check("busy_at_finish", busy, 0);
          check("max_hold_at_finish", max_hold, 1);
          check("hold_to_finish", cyc - mh_cyc, 1);
          check("src_sel_delay", first_src - first_acc, m_e.src_dly);
          if (m_e.stall)
            check("timeout_window",
                  ((mh_cyc - first_src) >= TO + 1) && ((mh_cyc - first_src) <= TO + 4), 1);
        end
      end
      prev_fin = finish;
      prev_mh  = max_hold;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1 check("reset_outputs",
             {in_accept, src_sel, pe_clear, pass_idx, busy, max_hold, finish, err}, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_finish(input int budget, input string name);
    int k = 0;
    while (!finish && k < budget) begin
      tick();
      k++;
    end
    check(name, finish, 1);
  endtask

  task automatic do_run(input int b, input int l2, input int g, input bit stall, input bit abort);
    exp_t e;
    e = model(b, l2, stall);
    if (!abort) exp_q.push_back(e);
    valid = 1'b1;
    repeat (b) tick();
    valid = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    pe_valid_out = 1'b1;
    if (stall) begin
      wait_finish(TO + 200, "stall_finish");
      pe_valid_out = 1'b0;
    end else begin
      repeat (IL) tick();
      pe_valid_out = 1'b0;
      repeat (g) tick();
      pe_valid_out = 1'b1;
      if (abort) begin
        repeat (20) tick();
        check("abort_in_recirc", {src_sel, pass_idx}, {1'b1, 2'(NP - 1)});
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check("async_reset_outputs",
                 {in_accept, src_sel, pe_clear, pass_idx, busy, max_hold, finish, err}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        pe_valid_out = 1'b0;
        tick();
        return;
      end
      repeat (l2) tick();
      pe_valid_out = 1'b0;
      wait_finish(50, "run_finish");
    end
    for (int i = 0; i < 6; i++) begin
      valid = 1'($urandom_range(0, 1));
      tick();
      check("post_finish", {in_accept, finish, pass_idx}, {1'b0, 1'b1, e.pidx});
    end
    valid = 1'b0;
    do_reset();
  endtask

  initial begin
    int b, l2, sel;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs",
             {in_accept, src_sel, pe_clear, pass_idx, busy, max_hold, finish, err}, 0);
    reset = 1'b1;
    tick();
    do_run(IL, IL, 1, 1'b0, 1'b0);
    do_run(200, 200, 1, 1'b0, 1'b0);
    do_run(260, IL, 1, 1'b0, 1'b0);
    do_run(IL, IL, 1, 1'b1, 1'b0);
    do_run(IL, IL, 1, 1'b0, 1'b1);
    do_run(IL, IL, 1, 1'b0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        1:       b = int'($urandom_range(150, 255));
        2:       b = int'($urandom_range(257, 270));
        default: b = IL;
      endcase
      l2 = ($urandom_range(0, 1) == 0) ? IL : int'($urandom_range(IL - 8, IL + 8));
      do_run(b, l2, int'($urandom_range(1, 3)), 1'b0, 1'b0);
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "bench time limit expired");
  end

endmodule
